// File: rtl/reconf_fir_tdm.sv
// rtl/reconf_fir_tdm.sv - time-multiplexed reconfigurable FIR with one pipelined MAC
module reconf_fir_tdm #(
    parameter int TAPS   = 16,
    parameter int DIN_W  = 3,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 32,
    parameter int DOUT_W = 16,
    parameter int SHIFT  = 0,
    localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iEnSample600k,
    input  logic [DIN_W-1:0]  iFirIn,
    input  logic              iCoeffUpdateFlag,
    input  logic              iCsnRam,
    input  logic              iWrnRam,
    input  logic [AW-1:0]     iAddrRam,
    input  logic [COEF_W-1:0] iWtDtRam,
    output logic [COEF_W-1:0] oRdDtRam,
    output logic [DOUT_W-1:0] oFirOut,
    output logic              oFirValid,
    output logic              oBusy,
    output logic              oSampleDrop
);
    localparam int CW = $clog2(TAPS + 1);
    localparam int PW = DIN_W + COEF_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_MAC    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CW-1:0] LAST_CNT = CW'(TAPS);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    logic [1:0]               state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PW-1:0]     prod_q, prod_d;
    logic signed [DIN_W-1:0]  dly_q  [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic [DOUT_W-1:0]        out_q;
    logic                     valid_q;
    logic [COEF_W-1:0]        rd_q;
    logic                     drop_q;

    logic                     shift_in;
    logic                     host_en;
    logic signed [DIN_W-1:0]  tap_d;
    logic signed [COEF_W-1:0] tap_c;
    logic [COEF_W-1:0]        rd_sel;
    logic signed [ACC_W-1:0]  shifted;
    logic [DOUT_W-1:0]        out_sat;

    assign shift_in = (state_q == S_IDLE) && !iCoeffUpdateFlag && iEnSample600k;
    assign host_en  = (state_q == S_UPDATE) && !iCsnRam;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (iCoeffUpdateFlag) begin
                    state_d = S_UPDATE;
                end else if (iEnSample600k) begin
                    state_d = S_MAC;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_UPDATE: begin
                if (!iCoeffUpdateFlag) state_d = S_IDLE;
            end
            S_MAC: begin
                // Product of tap j-1 lands in the accumulator while tap j is multiplied
                if (cnt_q != '0) acc_d = acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
                if (cnt_q == LAST_CNT) state_d = S_DONE;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            default: begin
                state_d = iCoeffUpdateFlag ? S_UPDATE : S_IDLE;
            end
        endcase
    end

    always_comb begin
        tap_d  = '0;
        tap_c  = '0;
        rd_sel = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (cnt_q == CW'(k)) begin
                tap_d = dly_q[k];
                tap_c = coef_q[k];
            end
            if (iAddrRam == AW'(k)) rd_sel = coef_q[k];
        end
        prod_d = $signed({{COEF_W{tap_d[DIN_W-1]}}, tap_d}) * $signed({{DIN_W{tap_c[COEF_W-1]}}, tap_c});
    end

    always_comb begin
        shifted = acc_q >>> SHIFT;
        if (shifted > SAT_MAX)      out_sat = SAT_MAX[DOUT_W-1:0];
        else if (shifted < SAT_MIN) out_sat = SAT_MIN[DOUT_W-1:0];
        else                        out_sat = shifted[DOUT_W-1:0];
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            rd_q    <= '0;
            drop_q  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                dly_q[k]  <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            valid_q <= (state_q == S_DONE);
            if (state_q == S_DONE) out_q <= out_sat;
            if (iEnSample600k && ((state_q == S_MAC) || (state_q == S_DONE))) drop_q <= 1'b1;
            if (shift_in) begin
                dly_q[0] <= iFirIn;
                for (int k = 1; k < TAPS; k++) dly_q[k] <= dly_q[k-1];
            end
            // Out-of-range addresses match no entry: writes vanish, reads give 0
            if (host_en) begin
                if (!iWrnRam) begin
                    for (int k = 0; k < TAPS; k++)
                        if (iAddrRam == AW'(k)) coef_q[k] <= iWtDtRam;
                end else begin
                    rd_q <= rd_sel;
                end
            end
        end
    end

    assign oRdDtRam    = rd_q;
    assign oFirOut     = out_q;
    assign oFirValid   = valid_q;
    assign oBusy       = (state_q == S_MAC) || (state_q == S_DONE);
    assign oSampleDrop = drop_q;

endmodule
